// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: load-use stall, branch flush and EX forward-select generation.
// Latency: Stall/Flush are combinational; EX_FwdA/B and the counters are registered (1 cycle after ID advance).
// Backpressure: Stall freezes PC and IF/ID and inserts a bubble into ID/EX; Redirect wins over Stall.
//
// Ports:
//   Clk, Rst                 single clock, synchronous active-high reset
//   ID_*                     decoded fields of the instruction currently in ID
//   Redirect                 taken branch/jump resolved in entry BR_ENTRY
//   CntClr                   synchronous clear of both performance counters
//   Stall, Flush             hazard outputs
//   EX_FwdA, EX_FwdB         forward selects for the EX instruction (0 = register file, k = entry k)
//   StallCnt, FlushCnt       saturating event counters
module pipe_hazard_ctrl #(
    parameter int DEPTH      = 3,
    parameter int AW         = 5,
    parameter int LOAD_AVAIL = 2,
    parameter int BR_ENTRY   = 1,
    parameter int CNTW       = 16
) (
    input  logic                       Clk,
    input  logic                       Rst,
    input  logic                       ID_Valid,
    input  logic [AW-1:0]              ID_Rs,
    input  logic [AW-1:0]              ID_Rt,
    input  logic                       ID_UseRs,
    input  logic                       ID_UseRt,
    input  logic                       ID_RegWr,
    input  logic                       ID_IsLoad,
    input  logic [AW-1:0]              ID_Rw,
    input  logic                       Redirect,
    input  logic                       CntClr,
    output logic                       Stall,
    output logic                       Flush,
    output logic [$clog2(DEPTH)-1:0]   EX_FwdA,
    output logic [$clog2(DEPTH)-1:0]   EX_FwdB,
    output logic [CNTW-1:0]            StallCnt,
    output logic [CNTW-1:0]            FlushCnt
);

    localparam int FW = $clog2(DEPTH);

    // In-flight entries after ID: index 0 = EX, 1 = MEM, ... DEPTH-1 = oldest.
    logic [DEPTH-1:0] ent_vld;
    logic [DEPTH-1:0] ent_wr;
    logic [DEPTH-1:0] ent_ld;
    logic [AW-1:0]    ent_rw [DEPTH];

    logic [DEPTH-1:0] match_rs;
    logic [DEPTH-1:0] match_rt;
    logic [DEPTH-1:0] load_win;
    logic             hazard;
    logic             advance;
    logic [FW-1:0]    fwd_a;
    logic [FW-1:0]    fwd_b;

    // Producer match per entry; register 0 never matches so it can never
    // forward or stall.
    always_comb begin
        match_rs = '0;
        match_rt = '0;
        load_win = '0;
        for (int j = 0; j < DEPTH; j++) begin
            match_rs[j] = ent_vld[j] & ent_wr[j] & (ent_rw[j] == ID_Rs) & (ID_Rs != '0);
            match_rt[j] = ent_vld[j] & ent_wr[j] & (ent_rw[j] == ID_Rt) & (ID_Rt != '0);
            // A load in entry j reaches the forwardable entry only after the
            // consumer would already be in EX when j+1 < LOAD_AVAIL.
            load_win[j] = (j + 1 < LOAD_AVAIL);
        end
    end

    assign hazard = ID_Valid &
                    ((ID_UseRs & (|(match_rs & ent_ld & load_win))) |
                     (ID_UseRt & (|(match_rt & ent_ld & load_win))));

    // Reset masks Stall so stale entries cannot hold the front end while Rst is high.
    assign Stall   = hazard & ~Redirect & ~Rst;
    assign Flush   = Redirect;
    assign advance = ~Stall & ~Redirect;

    // The youngest matching producer holds the newest value, so scan from the
    // oldest forwardable entry down to entry 0 and let the last hit win.
    always_comb begin
        fwd_a = '0;
        fwd_b = '0;
        for (int j = DEPTH - 2; j >= 0; j--) begin
            if (match_rs[j] & ID_UseRs) fwd_a = FW'(j + 1);
            if (match_rt[j] & ID_UseRt) fwd_b = FW'(j + 1);
        end
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            ent_vld  <= '0;
            ent_wr   <= '0;
            ent_ld   <= '0;
            for (int i = 0; i < DEPTH; i++) ent_rw[i] <= '0;
            EX_FwdA  <= '0;
            EX_FwdB  <= '0;
            StallCnt <= '0;
            FlushCnt <= '0;
        end else begin
            // Shift; entries up to BR_ENTRY after the shift are younger than the
            // taken branch and are squashed on Redirect.
            for (int i = 1; i < DEPTH; i++) begin
                ent_vld[i] <= ent_vld[i-1] & ~(Redirect & (i <= BR_ENTRY));
                ent_wr[i]  <= ent_wr[i-1];
                ent_ld[i]  <= ent_ld[i-1];
                ent_rw[i]  <= ent_rw[i-1];
            end
            ent_vld[0] <= advance & ID_Valid;
            ent_wr[0]  <= advance & ID_RegWr;
            ent_ld[0]  <= advance & ID_IsLoad;
            ent_rw[0]  <= ID_Rw;

            EX_FwdA <= advance ? fwd_a : '0;
            EX_FwdB <= advance ? fwd_b : '0;

            if (CntClr) begin
                StallCnt <= '0;
                FlushCnt <= '0;
            end else begin
                if (Stall && (StallCnt != '1))    StallCnt <= StallCnt + CNTW'(1);
                if (Redirect && (FlushCnt != '1)) FlushCnt <= FlushCnt + CNTW'(1);
            end
        end
    end

endmodule

// File: doc/pipe_hazard_ctrl.md
PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 Parameter DEPTH, default 3: tracked in-flight entries after ID (entry 0=EX, 1=MEM, 2=WR); legal range 2..8.
REQ-002 Parameter AW, default 5: register-address width.
REQ-003 Parameter LOAD_AVAIL, default 2: lowest entry index at which load data is forwardable; legal range 1..DEPTH-1.
REQ-004 Parameter BR_ENTRY, default 1: entry index holding the instruction that drives Redirect; legal range 0..DEPTH-1.
REQ-005 Parameter CNTW, default 16: performance-counter width.
REQ-006 Clk  in  1  single clock; all state updates on the rising edge.
REQ-007 Rst  in  1  reset; synchronous, active-high.
REQ-008 ID_Valid  in  1  the ID stage holds a real instruction.
REQ-009 ID_Rs, ID_Rt  in  AW each  source register addresses of the ID instruction.
REQ-010 ID_UseRs, ID_UseRt  in  1 each  the ID instruction reads Rs / Rt.
REQ-011 ID_RegWr, ID_IsLoad  in  1 each  the ID instruction writes a register / is a load.
REQ-012 ID_Rw  in  AW  destination register of the ID instruction.
REQ-013 Redirect  in  1  the branch or jump in entry BR_ENTRY is taken this cycle.
REQ-014 CntClr  in  1  synchronous clear of both counters.
REQ-015 Stall  out  1  combinational; freezes PC and IF/ID and inserts a bubble into ID/EX.
REQ-016 Flush  out  1  combinational; equal to Redirect.
REQ-017 EX_FwdA, EX_FwdB  out  clog2(DEPTH) each  registered forward selects for the EX instruction; 0=register file, k=result held in entry k.
REQ-018 StallCnt, FlushCnt  out  CNTW each  saturating event counters.

Function
REQ-019 Each entry SHALL hold {valid, regwr, isload, rw}; each cycle entry i+1 <= entry i, and entry DEPTH-1 retires (the register file is write-before-read).
REQ-020 Match(j, r) SHALL be defined as: entry j valid & regwr & rw==r & r!=0.
REQ-021 Hazard SHALL be: ID_Valid & an operand used with Match(j, operand) on an entry with isload=1, where j+1 < LOAD_AVAIL, checked for both Rs and Rt.
REQ-022 Stall SHALL be Hazard & ~Redirect; Redirect has priority over Stall.
REQ-023 Advance (~Stall & ~Redirect): entry 0 <= ID fields with valid=ID_Valid; EX_FwdA <= j+1 for the smallest j in 0..DEPTH-2 with Match(j, ID_Rs) & ID_UseRs, else 0; EX_FwdB is computed the same way using Rt.
REQ-024 Stall cycle: entry 0 <= bubble (valid=0); EX_FwdA/B <= 0; the ID instruction is re-evaluated next cycle.
REQ-025 Redirect cycle: entry 0 <= bubble; entries 1..BR_ENTRY <= invalid (younger than the branch); entries older than the branch shift normally; EX_FwdA/B <= 0.
REQ-026 Register 0 SHALL never cause a forward or a stall.
REQ-027 StallCnt SHALL increment on each Stall=1 cycle and FlushCnt on each Redirect=1 cycle; both saturate at 2^CNTW-1.
REQ-028 CntClr=1 SHALL zero both counters and drop any increment in that cycle; it does not affect entries.
REQ-029 The latency from ID advance to a valid EX_FwdA/B SHALL be 1 cycle.

Reset
REQ-030 While Rst=1: all entries invalid, EX_FwdA=EX_FwdB=0, StallCnt=FlushCnt=0, Stall=0.
REQ-031 Rst SHALL override Redirect and CntClr; reset mid-stream drops all in-flight tracking.
REQ-032 Rst asserted mid-stall SHALL leave Stall=0 from the next cycle until a new load-use pair occurs.

Verification (defaults unless stated)
REQ-033 add $3 then sub $4,$3,$1 on the next cycle -> no stall; EX_FwdA=1 while sub is in EX.
REQ-034 lw $5 then add $6,$5,$2 -> Stall=1 for exactly 1 cycle; StallCnt=1; then EX_FwdA=2.
REQ-035 Redirect=1 with valid instructions in ID and entry 0 -> Flush=1; next cycle entries 0 and 1 are invalid, EX_FwdA/B=0, FlushCnt=1.
REQ-036 Load-use hazard and Redirect in the same cycle -> Stall=0, Flush=1; StallCnt unchanged.
REQ-037 Producer writes $0, consumer reads $0 -> EX_FwdA=0, Stall=0 even if the producer is a load.
REQ-038 CNTW=4, 20 stall events -> StallCnt=15; CntClr pulse -> 0; Rst mid-stall -> all outputs 0 the next cycle.
